// File: rtl/sdram_pkg.sv
// ============================================================================
// sdram_pkg : SDRAM command encodings and timing constants shared by the
//             init and auto-refresh stages.
// Rev 1.0
// ============================================================================
`default_nettype none

package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0]  CMD_NOP     = 4'b0111;
  localparam logic [3:0]  CMD_PRECHAR = 4'b0010;
  localparam logic [3:0]  CMD_AREF    = 4'b0001;

  localparam logic [11:0] ADDR_A10    = 12'h400;

  // 750 cycles of 50 MHz = 15 us between refreshes
  localparam logic [9:0]  AREF_PERIOD = 10'd749;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } aref_state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_aref_timer.sv
// ============================================================================
// sdram_aref_timer : free-running refresh interval timer with expiry strobe,
//                    active only after SDRAM initialisation has completed.
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_aref_timer
  import sdram_pkg::*;
(
  input  logic s_clk,
  input  logic s_rst_n,
  input  logic flag_init_end,
  output logic expiry
);

  logic [9:0] timer;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n)
      timer <= '0;
    else if (!flag_init_end)
      timer <= '0;
    else if (timer == AREF_PERIOD)
      timer <= '0;
    else
      timer <= timer + 10'd1;
  end

  // Gated so a timer being cleared by a falling init flag cannot fire
  assign expiry = flag_init_end && (timer == AREF_PERIOD);

endmodule

`default_nettype wire

// File: rtl/sdram_aref.sv
// ============================================================================
// sdram_aref : SDRAM auto-refresh stage; requests the bus every 15 us and
//              issues PRECHARGE-ALL then AUTO-REFRESH once granted.
//              Define SDRAM_AREF_DOUBLE_EN to issue a second AREF per slot.
// Rev 1.0
// ============================================================================
`default_nettype none

module sdram_aref
  import sdram_pkg::*;
(
  input  logic        s_clk,
  input  logic        s_rst_n,
  input  logic        flag_init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  bank_addr,
  output logic        flag_aref_end,
  output logic        aref_overrun
);

`ifdef SDRAM_AREF_DOUBLE_EN
  localparam logic [3:0] CNT_LAST = 4'd9;
`else
  localparam logic [3:0] CNT_LAST = 4'd5;
`endif

  aref_state_t state;
  aref_state_t state_nxt;

  logic        expiry;
  logic        grant;
  logic        cnt_last;
  logic [3:0]  cmd_cnt;
  logic        pending;

  logic [3:0]  cmd_cnt_nxt;
  logic        pending_nxt;
  logic        aref_req_nxt;
  logic [3:0]  cmd_nxt;
  logic [11:0] addr_nxt;
  logic        aref_end_nxt;
  logic        overrun_nxt;

  sdram_aref_timer u_timer (
    .s_clk         (s_clk),
    .s_rst_n       (s_rst_n),
    .flag_init_end (flag_init_end),
    .expiry        (expiry)
  );

  // The grant only counts once the request is actually visible to the arbiter
  assign grant     = aref_req && aref_en;
  assign cnt_last  = (cmd_cnt == CNT_LAST);
  assign bank_addr = 2'b00;

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (expiry || pending) state_nxt = S_REQ;
      S_REQ:  if (grant)             state_nxt = S_RUN;
      S_RUN:  if (cnt_last)          state_nxt = S_END;
      S_END:                         state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    aref_req_nxt = (state == S_REQ) && !grant;
    aref_end_nxt = (state == S_RUN) && cnt_last;
    cmd_cnt_nxt  = (state == S_RUN) ? cmd_cnt + 4'd1 : 4'd0;
    overrun_nxt  = aref_overrun || (expiry && (state == S_REQ));
    cmd_nxt      = CMD_NOP;
    addr_nxt     = 12'h000;

    if (state == S_RUN) begin
      case (cmd_cnt)
        4'd0: begin
          cmd_nxt  = CMD_PRECHAR;
          addr_nxt = ADDR_A10;
        end
        4'd1: cmd_nxt = CMD_AREF;
`ifdef SDRAM_AREF_DOUBLE_EN
        4'd5: cmd_nxt = CMD_AREF;
`endif
        default: ;
      endcase
    end

    // An expiry during a running sequence is remembered; one in S_REQ is not
    if (!flag_init_end)
      pending_nxt = 1'b0;
    else if (expiry && ((state == S_RUN) || (state == S_END)))
      pending_nxt = 1'b1;
    else if ((state == S_IDLE) && (expiry || pending))
      pending_nxt = 1'b0;
    else
      pending_nxt = pending;
  end

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cmd_cnt       <= 4'd0;
      pending       <= 1'b0;
      aref_req      <= 1'b0;
      cmd           <= CMD_NOP;
      sdram_addr    <= 12'h000;
      flag_aref_end <= 1'b0;
      aref_overrun  <= 1'b0;
    end else begin
      cmd_cnt       <= cmd_cnt_nxt;
      pending       <= pending_nxt;
      aref_req      <= aref_req_nxt;
      cmd           <= cmd_nxt;
      sdram_addr    <= addr_nxt;
      flag_aref_end <= aref_end_nxt;
      aref_overrun  <= overrun_nxt;
    end
  end

endmodule

`default_nettype wire

// File: doc/sdram_aref.md
SDRAM_AREF -- requirements
Module: sdram_aref

Interface
REQ-001 SHALL have port s_clk, input, 1, 50 MHz system clock.
REQ-002 SHALL have port s_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flag_init_end, input, 1, sticky SDRAM-init-complete flag from the init stage.
REQ-004 SHALL have port aref_en, input, 1, arbiter grant; sampled only while aref_req is high.
REQ-005 SHALL have port aref_req, output, 1, refresh request to the arbiter.
REQ-006 SHALL have port cmd, output, 4, SDRAM command {CS_n,RAS_n,CAS_n,WE_n}.
REQ-007 SHALL have port sdram_addr, output, 12, address bus.
REQ-008 SHALL have port bank_addr, output, 2, bank address, constant 2'b00.
REQ-009 SHALL have port flag_aref_end, output, 1, one-cycle refresh-done pulse.
REQ-010 SHALL have port aref_overrun, output, 1, sticky missed-refresh flag.

Function
REQ-011 SHALL encode commands as NOP 4'b0111, PRECHAR 4'b0010, AREF 4'b0001.
REQ-012 SHALL run a 10-bit refresh timer counting 0..749 and wrapping (15 us), only while flag_init_end=1; held at 0 otherwise.
REQ-013 SHALL generate an expiry event when the timer equals 749; the first expiry falls 750 cycles after flag_init_end is first sampled high.
REQ-014 SHALL implement the FSM states S_IDLE, S_REQ, S_RUN and S_END.
REQ-015 SHALL move S_IDLE->S_REQ on expiry or on the pending bit, clearing the pending bit, and drive aref_req high from the cycle after S_REQ entry.
REQ-016 SHALL, in S_REQ with aref_en=1 at edge E0, enter S_RUN, drop aref_req and clear the 4-bit cmd_cnt; aref_en SHALL be ignored in all other states.
REQ-017 SHALL increment cmd_cnt by one each cycle in S_RUN, registering cmd from it: cnt0 PRECHAR with sdram_addr=12'h400 (A10, all banks); cnt1 AREF; other counts NOP with sdram_addr=0.
REQ-018 SHALL therefore show PRECHAR at E0+1 and AREF at E0+2.
REQ-019 SHALL, at the final count, pulse flag_aref_end for exactly one cycle, go to S_END, then return to S_IDLE on the next cycle.
REQ-020 SHALL, on expiry while in S_RUN or S_END, set the pending bit.
REQ-021 SHALL, on expiry while in S_REQ, set aref_overrun sticky with aref_req staying high, so only one refresh is performed.
REQ-022 SHALL output cmd=NOP outside S_RUN.
REQ-023 SHALL, if flag_init_end falls, clear the timer and pending bit and finish any S_RUN sequence normally before idling.

Reset
REQ-024 SHALL, on s_rst_n low, immediately force state S_IDLE, timer 0, cmd_cnt 0, pending 0, aref_req 0, cmd NOP, sdram_addr 0, flag_aref_end 0, aref_overrun 0, including mid-sequence.
REQ-025 SHALL clear aref_overrun only by reset.

Configuration
REQ-026 SHALL, with SDRAM_AREF_DOUBLE_EN defined, issue a second AREF at cnt5 (E0+6), with final count 9 and flag_aref_end at E0+10.
REQ-027 SHALL, without SDRAM_AREF_DOUBLE_EN, issue NOP at cnt5, with final count 5 and flag_aref_end at E0+6.

Structure
REQ-028 SHALL take the command encodings, the A10 precharge-all address constant and the 749 refresh-period constant from shared package sdram_pkg, also used by the init stage.
REQ-029 SHALL place the timer and expiry logic in one sub-module sdram_aref_timer; the FSM and command decode SHALL remain in sdram_aref.

Verification
REQ-030 SHALL cover: reset, flag_init_end=0 for 2000 cycles -> aref_req=0, cmd=4'b0111 throughout.
REQ-031 SHALL cover: flag_init_end rises at cycle T -> aref_req high at T+750 and repeats every 750 cycles when granted promptly.
REQ-032 SHALL cover: one-cycle aref_en at E0 with DOUBLE_EN -> cmd 0010 with addr 12'h400 at E0+1, 0001 at E0+2 and E0+6, flag_aref_end at E0+10 only, aref_req low from E0+1.
REQ-033 SHALL cover: the same stimulus without DOUBLE_EN -> single AREF at E0+2, flag_aref_end at E0+6.
REQ-034 SHALL cover: grant withheld 800 cycles after request -> aref_overrun=1 and remains 1; one refresh sequence is performed after the grant.
REQ-035 SHALL cover: s_rst_n low at cmd_cnt=3 -> all outputs at reset values that cycle; after release no command until flag_init_end plus 750 cycles.
